// File: rtl/quartsine_nco_pkg.sv
`default_nettype none
// ============================================================================
// Module      : quartsine_nco_pkg
// Description : Shared constants and helpers for the quarter-wave sine NCO:
//               midscale, quarter-table depth, quadrant field positions and
//               the elaboration-time ROM content generator.
// Revision    : 1.0 - initial release
// ============================================================================
package quartsine_nco_pkg;

    localparam int  QUAD_W = 2;
    localparam real C_PI   = 3.14159265358979323846;

    // Offset-binary midscale for a given sample width.
    function automatic int mid_value(input int data_w);
        return 1 << (data_w - 1);
    endfunction

    // Number of entries in the quarter-wave table.
    function automatic int quarter_depth(input int addr_w);
        return 1 << (addr_w - QUAD_W);
    endfunction

    // Quadrant field: the two MSBs of the full-wave table address.
    function automatic int quad_msb(input int addr_w);
        return addr_w - 1;
    endfunction

    function automatic int quad_lsb(input int addr_w);
        return addr_w - QUAD_W;
    endfunction

    // Quarter-wave entry: MID + round((MID-1) * sin(2*pi*(i+0.5)/2^addr_w)).
    // Sine is evaluated with a Taylor series so the constant function needs
    // no math library; the argument never exceeds pi/2, where 11 terms are
    // far below one LSB of error. The argument is positive, so adding 0.5
    // before truncation is a correct round-to-nearest.
    function automatic int rom_value(input int idx, input int addr_w, input int data_w);
        real x;
        real term;
        real s;
        int  mid;
        mid  = mid_value(data_w);
        x    = 2.0 * C_PI * (real'(idx) + 0.5) / real'(1 << addr_w);
        term = x;
        s    = x;
        for (int k = 1; k <= 11; k++) begin
            term = -term * x * x / real'((2 * k) * (2 * k + 1));
            s    = s + term;
        end
        return mid + $rtoi(real'(mid - 1) * s + 0.5);
    endfunction

endpackage
`default_nettype wire

// File: rtl/sinequarter_rom.sv
`default_nettype none
// ============================================================================
// Module      : sinequarter_rom
// Description : Quarter-wave sine table with a configurable number of
//               registered read stages. Content is fixed at elaboration.
// Revision    : 1.0 - initial release
// ============================================================================
module sinequarter_rom
    import quartsine_nco_pkg::*;
#(
    parameter int FULL_ADDR_W = 8,
    parameter int DATA_W      = 11,
    parameter int LATENCY     = 1
) (
    input  logic                     clk,
    input  logic [FULL_ADDR_W-3:0]   i_addr,
    output logic [DATA_W-1:0]        o_data
);

    localparam int DEPTH = quarter_depth(FULL_ADDR_W);

    logic [DATA_W-1:0] c_table [DEPTH];
    logic [DATA_W-1:0] r_pipe  [LATENCY];

    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_table
        localparam logic [DATA_W-1:0] C_ENTRY = DATA_W'(rom_value(gi, FULL_ADDR_W, DATA_W));
        assign c_table[gi] = C_ENTRY;
    end

    // Table read followed by LATENCY-1 extra retiming stages.
    always_ff @(posedge clk) begin
        r_pipe[0] <= c_table[i_addr];
        for (int i = 1; i < LATENCY; i++) begin
            r_pipe[i] <= r_pipe[i-1];
        end
    end

    assign o_data = r_pipe[LATENCY-1];

endmodule
`default_nettype wire

// File: rtl/quartsine_nco.sv
`default_nettype none
// ============================================================================
// Module      : quartsine_nco
// Description : Numerically controlled oscillator producing an offset-binary
//               full-wave sine from a quarter-wave table. Phase accumulator,
//               quadrant folding and output stage; the negate flag and valid
//               travel alongside the ROM so each fold meets its own sample.
// Revision    : 1.0 - initial release
// ============================================================================
module quartsine_nco
    import quartsine_nco_pkg::*;
#(
    parameter int PHASE_W     = 24,
    parameter int ADDR_W      = 8,
    parameter int DATA_W      = 11,
    parameter int ROM_LATENCY = 1
) (
    input  logic               clka,
    input  logic               resetn,
    input  logic               en,
    input  logic               fcw_wr,
    input  logic [PHASE_W-1:0] fcw_in,
    input  logic [PHASE_W-1:0] phase_off,
    input  logic               phase_clr,
    output logic               dout_valid,
    output logic [DATA_W-1:0]  douta
);

    localparam int                QMSB  = quad_msb(ADDR_W);
    localparam int                QLSB  = quad_lsb(ADDR_W);
    localparam logic [DATA_W-1:0] C_MID = DATA_W'(mid_value(DATA_W));

    logic [PHASE_W-1:0] r_acc;
    logic [PHASE_W-1:0] r_fcw;
    logic [ADDR_W-1:0]  r_addr;
    logic               r_va;
    logic               r_neg_dly [ROM_LATENCY];
    logic               r_v_dly   [ROM_LATENCY];

    logic [ADDR_W-1:0]  w_next_addr;
    logic [QLSB-1:0]    w_rom_idx;
    logic [DATA_W-1:0]  w_rom_data;
    logic [DATA_W-1:0]  w_folded;

    // Table address from the pre-increment accumulator plus the offset.
    assign w_next_addr = ADDR_W'((r_acc + phase_off) >> (PHASE_W - ADDR_W));

    // Odd quadrants read the quarter table backwards.
    assign w_rom_idx = r_addr[QLSB] ? ~r_addr[QLSB-1:0] : r_addr[QLSB-1:0];

    sinequarter_rom #(
        .FULL_ADDR_W (ADDR_W),
        .DATA_W      (DATA_W),
        .LATENCY     (ROM_LATENCY)
    ) u_rom (
        .clk    (clka),
        .i_addr (w_rom_idx),
        .o_data (w_rom_data)
    );

    // Lower half-wave mirrors about midscale: 2^DATA_W - rom in DATA_W bits.
    assign w_folded = r_neg_dly[ROM_LATENCY-1] ? (DATA_W'(0) - w_rom_data) : w_rom_data;

    // Frequency register, phase accumulator and address capture stage.
    always_ff @(posedge clka) begin
        if (!resetn) begin
            r_acc  <= '0;
            r_fcw  <= '0;
            r_addr <= '0;
            r_va   <= 1'b0;
        end else begin
            if (fcw_wr) begin
                r_fcw <= fcw_in;
            end
            if (phase_clr) begin
                r_acc <= '0;
                r_va  <= 1'b0;
            end else if (en) begin
                r_acc  <= r_acc + r_fcw;
                r_addr <= w_next_addr;
                r_va   <= 1'b1;
            end else begin
                r_va   <= 1'b0;
            end
        end
    end

    // Negate flag and valid delayed to match the ROM read latency.
    always_ff @(posedge clka) begin
        if (!resetn) begin
            for (int i = 0; i < ROM_LATENCY; i++) begin
                r_neg_dly[i] <= 1'b0;
                r_v_dly[i]   <= 1'b0;
            end
        end else begin
            r_neg_dly[0] <= r_addr[QMSB];
            r_v_dly[0]   <= r_va;
            for (int i = 1; i < ROM_LATENCY; i++) begin
                r_neg_dly[i] <= r_neg_dly[i-1];
                r_v_dly[i]   <= r_v_dly[i-1];
            end
        end
    end

    // Registered output; the sample holds while no new one arrives.
    always_ff @(posedge clka) begin
        if (!resetn) begin
            dout_valid <= 1'b0;
            douta      <= C_MID;
        end else begin
            dout_valid <= r_v_dly[ROM_LATENCY-1];
            if (r_v_dly[ROM_LATENCY-1]) begin
                douta <= w_folded;
            end
        end
    end

endmodule
`default_nettype wire
